fetch_stage: RTL and testbench

- Parametrised instruction-fetch stage with an IF/ID pipeline register.
- Holds the PC and increments it by a configurable step. Drives the instruction-memory address and latches the returned instruction, PC and next-PC into the IF/ID register.
- Adds behaviour the first-generation fetch path lacked: stall, flush, branch redirect, a valid bit and a saturating fetch counter.
- Sits between the instruction memory and the decode stage of the cpu.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/ifid_reg.sv | 54 +++++
 rtl/fetch_stage.sv | 122 ++++++++++++
 tb/tb_fetch_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared cpu pipeline constants and IF/ID record type
//
// Default fetch/decode widths, the opcode field position within an
// instruction word, and the IF/ID record that decode consumes.
package cpu_pkg;

  localparam int ADDR_W_DEF     = 8;
  localparam int INSTR_W_DEF    = 16;
  localparam int OPCODE_W_DEF   = 4;

  // The opcode occupies the most significant bits of the instruction word.
  localparam int OPCODE_MSB_DEF = INSTR_W_DEF - 1;
  localparam int OPCODE_LSB_DEF = INSTR_W_DEF - OPCODE_W_DEF;

  typedef struct packed {
    logic                   valid;
    logic [INSTR_W_DEF-1:0] instr;
    logic [ADDR_W_DEF-1:0]  pc;
    logic [ADDR_W_DEF-1:0]  pc_next;
  } ifid_t;

  function automatic logic [OPCODE_W_DEF-1:0] opcode_of(input logic [INSTR_W_DEF-1:0] instr);
    return instr[OPCODE_MSB_DEF -: OPCODE_W_DEF];
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - pipeline buffer with load/hold/kill controls and a valid bit
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset; clears valid and data
//   load      in   capture data_in and valid_in
//   valid_in  in   valid bit written when load is high
//   kill      in   when not loading, drop the valid bit but keep the data
//   data_in   in   DATA_W payload
//   valid_out out  registered valid bit
//   data_out  out  registered payload
module ifid_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W = INSTR_W_DEF + 2 * ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              valid_in,
  input  logic              kill,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      data_d  = data_in;
      valid_d = valid_in;
    end else if (kill) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with PC, IF/ID register and fetch counter
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous active-high reset
//   stall          in   hold PC and IF/ID contents
//   flush          in   invalidate IF/ID on the next edge
//   redirect_valid in   load PC from redirect_addr
//   redirect_addr  in   redirect target
//   imem_addr      out  instruction-memory address (current PC)
//   imem_data      in   instruction at imem_addr, same-cycle read
//   ifid_valid     out  IF/ID holds a live instruction
//   ifid_instr     out  latched instruction
//   ifid_opcode    out  opcode field of ifid_instr
//   ifid_pc        out  fetch address of the latched instruction
//   ifid_pc_next   out  ifid_pc + PC_INC, carry dropped
//   fetch_count    out  saturating count of instructions accepted into IF/ID
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int INSTR_W  = INSTR_W_DEF,
  parameter int OPCODE_W = OPCODE_W_DEF,
  parameter int PC_INC   = 2,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_addr,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INSTR_W-1:0]  imem_data,
  output logic                ifid_valid,
  output logic [INSTR_W-1:0]  ifid_instr,
  output logic [OPCODE_W-1:0] ifid_opcode,
  output logic [ADDR_W-1:0]   ifid_pc,
  output logic [ADDR_W-1:0]   ifid_pc_next,
  output logic [CNT_W-1:0]    fetch_count
);

  localparam int DATA_W = INSTR_W + 2 * ADDR_W;

  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(PC_INC);
  localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ADDR_W-1:0] pc_plus;
  logic              reg_load;
  logic              reg_valid_in;
  logic              reg_kill;
  logic [DATA_W-1:0] reg_data_in;
  logic [DATA_W-1:0] reg_data_out;

  // Adding in ADDR_W bits drops the carry, so the PC wraps naturally.
  assign pc_plus     = pc_q + PC_STEP;
  assign reg_data_in = {imem_data, pc_q, pc_plus};

  always_comb begin
    pc_d         = pc_q;
    reg_load     = 1'b0;
    reg_valid_in = 1'b0;
    reg_kill     = 1'b0;
    if (redirect_valid) begin
      // The word fetched this cycle is wrong-path: load it (keeps data
      // defined) but mark the entry invalid, regardless of stall.
      pc_d         = redirect_addr;
      reg_load     = 1'b1;
      reg_valid_in = 1'b0;
    end else if (stall) begin
      reg_kill     = flush;
    end else begin
      pc_d         = pc_plus;
      reg_load     = 1'b1;
      reg_valid_in = !flush;
    end
  end

  // Only a fresh accepted fetch counts; a held valid entry under stall does not.
  always_comb begin
    cnt_d = cnt_q;
    if (reg_load && reg_valid_in && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= PC_RESET;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  ifid_reg #(
    .DATA_W (DATA_W)
  ) u_ifid_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (reg_load),
    .valid_in  (reg_valid_in),
    .kill      (reg_kill),
    .data_in   (reg_data_in),
    .valid_out (ifid_valid),
    .data_out  (reg_data_out)
  );

  assign imem_addr    = pc_q;
  assign ifid_instr   = reg_data_out[DATA_W-1 -: INSTR_W];
  assign ifid_pc      = reg_data_out[2*ADDR_W-1 -: ADDR_W];
  assign ifid_pc_next = reg_data_out[ADDR_W-1:0];
  assign ifid_opcode  = ifid_instr[INSTR_W-1 -: OPCODE_W];
  assign fetch_count  = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, redirect_valid;
  logic [7:0]  redirect_addr;
  logic [7:0]  imem_addr, imem_addr_s;
  logic [15:0] imem_data, imem_data_s;
  logic        ifid_valid, ifid_valid_s;
  logic [15:0] ifid_instr, ifid_instr_s;
  logic [3:0]  ifid_opcode, ifid_opcode_s;
  logic [7:0]  ifid_pc, ifid_pc_s;
  logic [7:0]  ifid_pc_next, ifid_pc_next_s;
  logic [15:0] fetch_count;
  logic [2:0]  fetch_count_s;

  logic [15:0] mem [256];

  int n_total = 0;
  int n_bad   = 0;

  // Reference state
  int m_pc, m_valid, m_instr, m_ipc, m_ipcn, m_cnt, m_cnt_s;
  bit m_known;

  always #5 clk = ~clk;

  assign imem_data   = mem[imem_addr];
  assign imem_data_s = mem[imem_addr_s];

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_opcode(ifid_opcode),
    .ifid_pc(ifid_pc), .ifid_pc_next(ifid_pc_next), .fetch_count(fetch_count)
  );

  fetch_stage #(.CNT_W(3)) dut_s (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_addr(imem_addr_s), .imem_data(imem_data_s),
    .ifid_valid(ifid_valid_s), .ifid_instr(ifid_instr_s), .ifid_opcode(ifid_opcode_s),
    .ifid_pc(ifid_pc_s), .ifid_pc_next(ifid_pc_next_s), .fetch_count(fetch_count_s)
  );

  // Advance the reference by one edge from the current inputs, then clock.
  task automatic step();
    if (reset) begin
      m_pc = 0; m_valid = 0; m_instr = 0; m_ipc = 0; m_ipcn = 0;
      m_cnt = 0; m_cnt_s = 0; m_known = 1;
    end else if (redirect_valid) begin
      m_pc = int'(redirect_addr); m_valid = 0; m_known = 0;
    end else if (stall) begin
      if (flush) m_valid = 0;
    end else begin
      m_instr = int'(mem[m_pc]);
      m_ipc   = m_pc;
      m_ipcn  = (m_pc + 2) % 256;
      m_pc    = (m_pc + 2) % 256;
      m_valid = flush ? 0 : 1;
      m_known = 1;
      if (m_valid == 1) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_s < 7) m_cnt_s++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; stall = 0; flush = 0; redirect_valid = 0; redirect_addr = 8'h00;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
    idle_inputs();
    reset = 1;
    repeat (3) step();
    n_total++; if (imem_addr !== 8'h00) begin n_bad++; $display("FAIL reset_addr: got %h want 00", imem_addr); end
    n_total++; if (ifid_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", ifid_valid); end
    n_total++; if ({ifid_instr, ifid_pc, ifid_pc_next} !== 32'h0) begin n_bad++;
      $display("FAIL reset_data: got %h %h %h want 0", ifid_instr, ifid_pc, ifid_pc_next); end
    n_total++; if (fetch_count !== 16'd0 || fetch_count_s !== 3'd0) begin n_bad++;
      $display("FAIL reset_count: got %0d/%0d want 0/0", fetch_count, fetch_count_s); end
  endtask

  task automatic test_sequential();
    reset = 0;
    for (int k = 1; k <= 3; k++) begin
      step();
      n_total++; if (imem_addr !== 8'(2 * k)) begin n_bad++; $display("FAIL seq_addr%0d: got %h want %h", k, imem_addr, 8'(2 * k)); end
      n_total++; if (ifid_pc !== 8'(2 * (k - 1)) || ifid_valid !== 1'b1) begin n_bad++;
        $display("FAIL seq_ifid%0d: got pc=%h v=%b want pc=%h v=1", k, ifid_pc, ifid_valid, 8'(2 * (k - 1))); end
      n_total++; if (ifid_opcode !== 4'hA || ifid_instr !== 16'hA000 + 16'(2 * (k - 1))) begin n_bad++;
        $display("FAIL seq_instr%0d: got %h want %h", k, ifid_instr, 16'hA000 + 16'(2 * (k - 1))); end
      n_total++; if (fetch_count !== 16'(k)) begin n_bad++; $display("FAIL seq_count%0d: got %0d want %0d", k, fetch_count, k); end
    end
  endtask

  task automatic test_stall();
    stall = 1;
    repeat (2) begin
      step();
      n_total++; if (imem_addr !== 8'h06 || ifid_pc !== 8'h04) begin n_bad++;
        $display("FAIL stall_hold: got addr=%h pc=%h want 06/04", imem_addr, ifid_pc); end
      n_total++; if (fetch_count !== 16'd3 || ifid_valid !== 1'b1) begin n_bad++;
        $display("FAIL stall_count: got %0d v=%b want 3 v=1", fetch_count, ifid_valid); end
    end
    stall = 0;
    step();
    n_total++; if (ifid_pc !== 8'h06 || imem_addr !== 8'h08 || fetch_count !== 16'd4) begin n_bad++;
      $display("FAIL stall_resume: got pc=%h addr=%h cnt=%0d want 06/08/4", ifid_pc, imem_addr, fetch_count); end
  endtask

  task automatic test_redirect();
    step();
    n_total++; if (imem_addr !== 8'h0A) begin n_bad++; $display("FAIL redir_pre: got %h want 0A", imem_addr); end
    redirect_valid = 1; redirect_addr = 8'h40; stall = 1;
    step();
    redirect_valid = 0; stall = 0;
    n_total++; if (ifid_valid !== 1'b0 || imem_addr !== 8'h40) begin n_bad++;
      $display("FAIL redir_edge: got v=%b addr=%h want 0/40", ifid_valid, imem_addr); end
    n_total++; if ($isunknown({ifid_instr, ifid_pc, ifid_pc_next})) begin n_bad++;
      $display("FAIL redir_nox: got %h %h %h want no X", ifid_instr, ifid_pc, ifid_pc_next); end
    step();
    n_total++; if (ifid_valid !== 1'b1 || ifid_pc !== 8'h40 || ifid_instr !== 16'hA040) begin n_bad++;
      $display("FAIL redir_target: got v=%b pc=%h i=%h want 1/40/A040", ifid_valid, ifid_pc, ifid_instr); end
  endtask

  task automatic test_flush();
    redirect_valid = 1; redirect_addr = 8'h10; step(); redirect_valid = 0;
    flush = 1; step(); flush = 0;
    n_total++; if (ifid_valid !== 1'b0 || imem_addr !== 8'h12 || ifid_pc !== 8'h10) begin n_bad++;
      $display("FAIL flush_alone: got v=%b addr=%h pc=%h want 0/12/10", ifid_valid, imem_addr, ifid_pc); end
    redirect_valid = 1; redirect_addr = 8'h1E; step(); redirect_valid = 0;
    step();
    n_total++; if (ifid_valid !== 1'b1 || imem_addr !== 8'h20) begin n_bad++;
      $display("FAIL flush_setup: got v=%b addr=%h want 1/20", ifid_valid, imem_addr); end
    stall = 1; flush = 1; step(); stall = 0; flush = 0;
    n_total++; if (ifid_valid !== 1'b0 || imem_addr !== 8'h20 || ifid_pc !== 8'h1E) begin n_bad++;
      $display("FAIL stall_flush: got v=%b addr=%h pc=%h want 0/20/1E", ifid_valid, imem_addr, ifid_pc); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1; redirect_addr = 8'hFE; step(); redirect_valid = 0;
    n_total++; if (imem_addr !== 8'hFE) begin n_bad++; $display("FAIL wrap_fe: got %h want FE", imem_addr); end
    step();
    n_total++; if (imem_addr !== 8'h00 || ifid_pc !== 8'hFE || ifid_pc_next !== 8'h00) begin n_bad++;
      $display("FAIL wrap_next: got addr=%h pc=%h nx=%h want 00/FE/00", imem_addr, ifid_pc, ifid_pc_next); end
  endtask

  task automatic test_reset_mid();
    step();
    reset = 1; stall = 1; redirect_valid = 1; redirect_addr = 8'h77; flush = 1;
    step();
    idle_inputs();
    n_total++; if (imem_addr !== 8'h00 || ifid_valid !== 1'b0) begin n_bad++;
      $display("FAIL rstmid_state: got addr=%h v=%b want 00/0", imem_addr, ifid_valid); end
    n_total++; if (fetch_count !== 16'd0 || fetch_count_s !== 3'd0) begin n_bad++;
      $display("FAIL rstmid_count: got %0d/%0d want 0/0", fetch_count, fetch_count_s); end
  endtask

  task automatic test_saturation();
    for (int k = 1; k <= 10; k++) begin
      step();
      n_total++; if (fetch_count_s !== 3'((k > 7) ? 7 : k) || fetch_count !== 16'(k)) begin n_bad++;
        $display("FAIL sat_count%0d: got %0d/%0d want %0d/%0d", k, fetch_count_s, fetch_count, (k > 7) ? 7 : k, k); end
    end
    n_total++; if (ifid_valid_s !== ifid_valid || imem_addr_s !== imem_addr) begin n_bad++;
      $display("FAIL sat_pipe: got v=%b addr=%h want v=%b addr=%h", ifid_valid_s, imem_addr_s, ifid_valid, imem_addr); end
  endtask

  task automatic test_random();
    int bad_before;
    bad_before = n_bad;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    for (int c = 0; c < 400; c++) begin
      reset          = ($urandom_range(0, 49) == 0);
      stall          = ($urandom_range(0, 3) == 0);
      flush          = ($urandom_range(0, 5) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_addr  = 8'($urandom);
      step();
      n_total++;
      if (imem_addr !== 8'(m_pc) || ifid_valid !== 1'(m_valid) || fetch_count !== 16'(m_cnt)
          || fetch_count_s !== 3'(m_cnt_s) || imem_addr_s !== 8'(m_pc)) begin
        n_bad++;
        $display("FAIL rand_ctl c%0d: got addr=%h v=%b cnt=%0d/%0d want addr=%h v=%0d cnt=%0d/%0d",
                 c, imem_addr, ifid_valid, fetch_count, fetch_count_s, m_pc, m_valid, m_cnt, m_cnt_s);
      end
      if (m_known) begin
        n_total++;
        if (ifid_instr !== 16'(m_instr) || ifid_pc !== 8'(m_ipc) || ifid_pc_next !== 8'(m_ipcn)
            || ifid_opcode !== 4'(m_instr >> 12) || ifid_instr_s !== ifid_instr
            || ifid_opcode_s !== ifid_opcode || {ifid_pc_s, ifid_pc_next_s} !== {ifid_pc, ifid_pc_next}) begin
          n_bad++;
          $display("FAIL rand_data c%0d: got i=%h pc=%h nx=%h want i=%h pc=%h nx=%h",
                   c, ifid_instr, ifid_pc, ifid_pc_next, 16'(m_instr), 8'(m_ipc), 8'(m_ipcn));
        end
      end
      if (n_bad - bad_before > 10) break;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_flush();
    test_wrap();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
